// File: rtl/fsm_stim_driver.sv
// Stimulus/response engine: plays a preloaded table of {X1,X2,X3} vectors and logs Y once per vector.
// Optional expected-response compare is enabled by defining FSM_STIM_CHECK_EN.
module fsm_stim_driver #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_data,
  input  logic [ADDR_W-1:0] len,
  input  logic [HOLD_W-1:0] hold,
  input  logic              start,
  input  logic              Y,
  output logic              X1,
  output logic              X2,
  output logic              X3,
  output logic              busy,
  output logic              done,
  output logic [DEPTH-1:0]  y_log,
  output logic [ADDR_W:0]   y_ones
`ifdef FSM_STIM_CHECK_EN
  ,
  input  logic [DEPTH-1:0]  exp_log,
  output logic              pass
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q;
  logic [2:0]          mem_q [DEPTH];
  logic [2:0]          x_q;
  logic                busy_q;
  logic                done_q;
  logic [DEPTH-1:0]    y_log_q;
  logic [ADDR_W:0]     y_ones_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;
  logic [ADDR_W-1:0]   len_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_cnt_q;

`ifdef FSM_STIM_CHECK_EN
  logic [DEPTH-1:0]    exp_log_q;
  logic                pass_q;

  function automatic logic [DEPTH-1:0] len_mask(input logic [ADDR_W-1:0] l);
    logic [DEPTH-1:0] m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (ADDR_W'(i) <= l);
    end
    return m;
  endfunction

  assign pass = pass_q;
`endif

  always_comb begin
    addr_d = addr_q + ADDR_W'(1);
  end

  // The table survives rst; writes lose to a simultaneous start.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && wr_en && !start) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      y_log_q    <= '0;
      y_ones_q   <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
`ifdef FSM_STIM_CHECK_EN
      exp_log_q  <= '0;
      pass_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            len_q      <= len;
            hold_q     <= hold;
            y_log_q    <= '0;
            y_ones_q   <= '0;
            addr_q     <= '0;
            hold_cnt_q <= '0;
            x_q        <= mem_q[0];
            busy_q     <= 1'b1;
            state_q    <= S_DRIVE;
`ifdef FSM_STIM_CHECK_EN
            exp_log_q  <= exp_log;
            pass_q     <= 1'b0;
`endif
          end
        end
        S_DRIVE: begin
          if (hold_cnt_q == hold_q) begin
            state_q <= S_SAMPLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        S_SAMPLE: begin
          y_log_q[addr_q] <= Y;
          y_ones_q        <= y_ones_q + {{ADDR_W{1'b0}}, Y};
          // Terminate on the compare so a full-table run never wraps addr.
          if (addr_q == len_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            addr_q     <= addr_d;
            x_q        <= mem_q[addr_d];
            hold_cnt_q <= '0;
            state_q    <= S_DRIVE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
`ifdef FSM_STIM_CHECK_EN
          pass_q  <= (((y_log_q ^ exp_log_q) & len_mask(len_q)) == '0);
`endif
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign X1     = x_q[2];
  assign X2     = x_q[1];
  assign X3     = x_q[0];
  assign busy   = busy_q;
  assign done   = done_q;
  assign y_log  = y_log_q;
  assign y_ones = y_ones_q;

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Randomized self-checking bench for fsm_stim_driver against a cycle-count reference model.
module tb_fsm_stim_driver;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int HOLD_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;
  logic [ADDR_W-1:0] len;
  logic [HOLD_W-1:0] hold;
  logic              start;
  logic              Y;
  logic              X1, X2, X3;
  logic              busy, done;
  logic [DEPTH-1:0]  y_log;
  logic [ADDR_W:0]   y_ones;
`ifdef FSM_STIM_CHECK_EN
  logic [DEPTH-1:0]  exp_log;
  logic              pass;
`endif

  int checks = 0;
  int errors = 0;
  logic [2:0] tbl [DEPTH];

  fsm_stim_driver #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .hold(hold), .start(start), .Y(Y),
    .X1(X1), .X2(X2), .X3(X3), .busy(busy), .done(done),
    .y_log(y_log), .y_ones(y_ones)
`ifdef FSM_STIM_CHECK_EN
    , .exp_log(exp_log), .pass(pass)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xv();
    return 32'({X1, X2, X3});
  endfunction

  task automatic write_entry(input int a, input logic [2:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    tbl[a] = d;
  endtask

  // ymode: 0 random, 1 Y=X1, 2 Y=X1^X3, 3 Y=1
  task automatic run(input int l, input int h, input int ymode, input bit collide,
                     input bit noise, input logic [DEPTH-1:0] exp_in,
                     output logic [DEPTH-1:0] ylog_out, output int ones_out);
    int n;
    int k;
    logic [DEPTH-1:0] ylog_m;
    logic [DEPTH-1:0] mask;
    int ones_m;
    n = (l + 1) * (h + 2);
    ylog_m = '0;
    ones_m = 0;
    @(negedge clk);
    start = 1'b1; len = ADDR_W'(l); hold = HOLD_W'(h);
`ifdef FSM_STIM_CHECK_EN
    exp_log = exp_in;
`endif
    if (collide) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = ~tbl[0];
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= n + 1; c++) begin
      if (c <= n) begin
        k = (c - 1) / (h + 2);
        check_eq("x_drive", xv(), 32'(tbl[k]));
        check_eq("busy_run", 32'(busy), 32'd1);
        check_eq("done_early", 32'(done), 32'd0);
`ifdef FSM_STIM_CHECK_EN
        if (c == 1) check_eq("pass_clr", 32'(pass), 32'd0);
`endif
        case (ymode)
          1:       Y = tbl[k][2];
          2:       Y = tbl[k][2] ^ tbl[k][0];
          3:       Y = 1'b1;
          default: Y = 1'($urandom);
        endcase
        if ((c - 1) % (h + 2) == h + 1) begin
          ylog_m[k] = Y;
          ones_m += int'(Y);
        end
        if (noise) begin
          start = 1'($urandom); wr_en = 1'($urandom);
          wr_addr = ADDR_W'($urandom); wr_data = 3'($urandom);
          len = ADDR_W'($urandom); hold = HOLD_W'($urandom);
        end
      end else begin
        start = 1'b0; wr_en = 1'b0;
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("busy_done", 32'(busy), 32'd0);
        check_eq("x_last", xv(), 32'(tbl[l]));
        check_eq("ylog", 32'(y_log), 32'(ylog_m));
        check_eq("yones", 32'(y_ones), 32'(ones_m));
      end
      @(negedge clk);
    end
    check_eq("done_once", 32'(done), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("x_hold", xv(), 32'(tbl[l]));
    check_eq("ylog_stable", 32'(y_log), 32'(ylog_m));
    check_eq("yones_stable", 32'(y_ones), 32'(ones_m));
    mask = '0;
    for (int i = 0; i <= l; i++) mask[i] = 1'b1;
`ifdef FSM_STIM_CHECK_EN
    check_eq("pass", 32'(pass), 32'(((ylog_m ^ exp_in) & mask) == '0));
`endif
    ylog_out = ylog_m;
    ones_out = ones_m;
  endtask

  initial begin
    logic [DEPTH-1:0] yl;
    int yo;
    logic [DEPTH-1:0] ex;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; hold = '0; start = 1'b0; Y = 1'b0;
`ifdef FSM_STIM_CHECK_EN
    exp_log = '0;
`endif
    #12;
    check_eq("rst_x", xv(), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ylog", 32'(y_log), 32'd0);
    check_eq("rst_yones", 32'(y_ones), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Three-vector run
    write_entry(0, 3'b110); write_entry(1, 3'b010); write_entry(2, 3'b001);
    run(2, 0, 1, 1'b0, 1'b0, 16'h0001, yl, yo);
    check_eq("3v_ylog", 32'(yl), 32'h0001);
    check_eq("3v_yones", 32'(yo), 32'd1);
`ifdef FSM_STIM_CHECK_EN
    check_eq("3v_pass1", 32'(pass), 32'd1);
    run(2, 0, 1, 1'b0, 1'b0, 16'h0003, yl, yo);
    check_eq("3v_pass0", 32'(pass), 32'd0);
    run(2, 0, 1, 1'b0, 1'b0, 16'hFFF1, yl, yo);
    check_eq("3v_passmask", 32'(pass), 32'd1);
`endif

    // Hold stretch
    write_entry(0, 3'b111);
    run(0, 3, 3, 1'b0, 1'b0, 16'h0001, yl, yo);
    check_eq("hold_yones", 32'(yo), 32'd1);

    // Full table
    for (int i = 0; i < DEPTH; i++) write_entry(i, 3'(i % 8));
    run(15, 0, 2, 1'b0, 1'b0, 16'h5A5A, yl, yo);
    check_eq("full_ylog", 32'(y_log), 32'h5A5A);
    check_eq("full_yones", 32'(y_ones), 32'd8);

    // Start+write collision and ignored inputs while busy, then confirm table intact
    run(15, 1, 0, 1'b1, 1'b1, 16'h0000, yl, yo);
    run(15, 0, 0, 1'b0, 1'b0, 16'h0000, yl, yo);

    // Reset mid-DRIVE
    Y = 1'b1;
    @(negedge clk);
    start = 1'b1; len = ADDR_W'(3); hold = HOLD_W'(2);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_x", xv(), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ylog", 32'(y_log), 32'd0);
    check_eq("mid_rst_yones", 32'(y_ones), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(3, 2, 0, 1'b0, 1'b0, 16'h0000, yl, yo);

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      int wl;
      int l;
      wl = int'($urandom_range(0, 4));
      for (int j = 0; j < wl; j++) write_entry(int'($urandom_range(0, DEPTH - 1)), 3'($urandom));
      l = int'($urandom_range(0, DEPTH - 1));
      ex = DEPTH'($urandom);
      run(l, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'($urandom),
          1'($urandom), ex, yl, yo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsm_stim_driver.md
Name: fsm_stim_driver

Overview:
- Hardware stimulus/response engine for small FSM labs. Drives the X1/X2/X3 inputs of an FSM under test and captures its Y output, in step with the FSM's own clock.
- Vectors are preloaded into an internal table, played back in order, each held for a programmable number of cycles. The response Y is sampled once per vector.
- Sits opposite the lab FSM: this block produces X and consumes Y, replacing a hand-written stimulus loop.

Parameters:
- DEPTH, 16, number of 3-bit vector table entries (power of two).
- ADDR_W, 4, table address width; DEPTH = 2**ADDR_W.
- HOLD_W, 4, width of per-vector hold count.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  table write strobe; honoured only in IDLE.
- wr_addr  in  ADDR_W  table write address.
- wr_data  in  3  vector {X1,X2,X3}; bit 2 = X1.
- len  in  ADDR_W  index of last vector to play; count = len+1; sampled at start.
- hold  in  HOLD_W  extra drive cycles per vector; sampled at start.
- start  in  1  launch playback; honoured only in IDLE.
- Y  in  1  response from FSM under test.
- X1, X2, X3  out  1 each  registered stimulus.
- busy  out  1  high in DRIVE and SAMPLE.
- done  out  1  one-cycle pulse when the run completes.
- y_log  out  DEPTH  captured Y per vector; bit i = vector i.
- y_ones  out  ADDR_W+1  count of captured Y=1.

Behaviour:
- Reset (async, immediate): state=IDLE; X1..X3=0; busy=0; done=0; y_log=0; y_ones=0; counters=0. Table contents are not cleared by rst.
- IDLE:
  - wr_en writes mem[wr_addr]=wr_data at the clock edge.
  - start latches len and hold, clears y_log and y_ones, sets addr=0, loads {X1,X2,X3}=mem[0], and moves to DRIVE.
  - If start and wr_en occur in the same cycle, start takes priority and the write is dropped.
- DRIVE:
  - X holds mem[addr] for hold+1 cycles; hold=0 gives 1 cycle, hold=15 gives 16 cycles.
  - Then moves to SAMPLE.
- SAMPLE (1 cycle):
  - X is still held.
  - At the closing edge: y_log[addr]<=Y; y_ones<=y_ones+Y.
  - If addr==len: next state is DONE. X stays at the last vector.
  - Otherwise: addr<=addr+1, X<=mem[addr+1], next state is DRIVE.
- DONE (1 cycle): done=1, busy=0, then IDLE. X holds the last vector until the next start or rst.
- Cycle counts:
  - Per vector: hold+2 cycles.
  - Full run: (len+1)*(hold+2)+1 cycles from the start edge to the done pulse.
- busy is asserted from the cycle after start is accepted through the last SAMPLE cycle.
- Ignored inputs:
  - wr_en and start are ignored outside IDLE.
  - Changes to len/hold during a run have no effect.
- Boundaries:
  - len=0 plays one vector.
  - len=DEPTH-1 plays the whole table; addr does not wrap, because termination happens on the compare.
  - y_ones saturation is not needed, since width ADDR_W+1 holds DEPTH.
- y_log/y_ones remain stable after done until the next accepted start.
- Reset mid-run aborts immediately with all outputs at reset values. The table remains intact.

Optional Feature:
- Macro: FSM_STIM_CHECK_EN.
- With the macro:
  - Adds input exp_log[DEPTH-1:0] (sampled at start) and output pass (1 bit, reset 0).
  - On the DONE cycle, pass<=((y_log ^ exp_log) & mask)==0, where mask has bits 0..len set.
  - pass is cleared at start and holds until the next start.
- Without the macro: no exp_log/pass ports and no compare logic; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-DRIVE with len=3 -> X1..X3=0, busy=0, y_log=0 immediately. After release, a start replays the original table unchanged.
- Three-vector run:
  - Setup: table {110,010,001}, len=2, hold=0, Y tied to X1.
  - X sequence: 110 for 2 cycles, 010 for 2, 001 for 2.
  - Results: y_log[2:0]=001, y_ones=1, done 7 cycles after start.
- Hold stretch: hold=3, len=0, table[0]=111, Y=1 -> X=111 for 5 cycles; y_log[0]=1, y_ones=1; done at cycle 6.
- Full table: 16 vectors 0..7 repeating, Y=X1^X3, len=15 -> y_ones=8. Pattern of bits 0..15 = 0101101001011010 (bit i = vec[2]^vec[0]). No address wrap.
- Ignored inputs:
  - start and wr_en during busy -> no restart, table unchanged.
  - start+wr_en together in IDLE -> run begins and the write is dropped.
- FSM_STIM_CHECK_EN:
  - Same as the three-vector run with exp_log=16'h0001 -> pass=1.
  - Same run with exp_log=16'h0003 -> pass=0.
  - exp_log=16'hFFF1 with len=2 -> pass=1 (bits above len are masked).
